// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if
//   The command/response bus between the arbiter and the shared i2c_master engine.
//
//   Modports:
//     master : used by the arbiter, which drives commands into the engine.
//     slave  : used by the i2c_master engine, or by a model of it.
//
//   Signals:
//     m_start      start pulse, one cycle long
//     m_rw_bit     R/W bit (1 = read)
//     m_slave_addr 7-bit slave address
//     m_tx_data    write byte
//     m_rx_data    read byte returned by the engine
//     m_busy       engine busy level
//     m_done       engine completion pulse
//     m_ack_error  engine NACK flag, valid together with m_done
//
// Handshake: a command is accepted by the engine on the single cycle where
// m_start is 1. The address, R/W and data fields are stable from that cycle
// until the next start. The engine may raise m_busy after the start, and it
// reports completion with a one-cycle m_done. m_rx_data and m_ack_error are
// only meaningful in the cycle where m_done is 1.
`timescale 1ns/1ps
interface i2c_master_arbiter_if;
  logic       m_start;
  logic       m_rw_bit;
  logic [6:0] m_slave_addr;
  logic [7:0] m_tx_data;
  logic [7:0] m_rx_data;
  logic       m_busy;
  logic       m_done;
  logic       m_ack_error;

  modport master (
    output m_start, m_rw_bit, m_slave_addr, m_tx_data,
    input  m_rx_data, m_busy, m_done, m_ack_error
  );

  modport slave (
    input  m_start, m_rw_bit, m_slave_addr, m_tx_data,
    output m_rx_data, m_busy, m_done, m_ack_error
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Lets NUM_REQ requesters share one i2c_master engine, using round-robin
//   arbitration.
//   - The winner's transaction fields are latched.
//   - A one-cycle start is issued to the engine.
//   - The engine's busy/done handshake is followed.
//   - A one-cycle response (read byte and status) goes back to the owner.
//   - A watchdog aborts transactions that never finish.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   req/req_rw      per-requester request level and R/W bit
//   req_addr        7 bits per requester; requester i uses [7i+6:7i]
//   req_data        8 bits per requester; requester i uses [8i+7:8i]
//   gnt             one-hot owner of the engine; 0 when idle
//   rsp_valid       one-cycle response pulse to the owner
//   rsp_rx_data     read byte, shared by all requesters
//   rsp_ack_error   NACK or timeout
//   rsp_timeout     the watchdog aborted the transaction
//   arb_busy        the FSM is not in IDLE
//   dbg_state       current FSM state, for observation
//   mbus            command/response bus to the engine (master modport)
//
// All outputs are registered. Each one is loaded from its next-state value
// in the same always_ff as the state register.
`timescale 1ns/1ps
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rx_data,
  output logic                   rsp_ack_error,
  output logic                   rsp_timeout,
  output logic                   arb_busy,
  output logic [2:0]             dbg_state,
  i2c_master_arbiter_if.master   mbus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] gnt_d, rsp_valid_d;
  logic [7:0]         rx_d, tx_d;
  logic [6:0]         addr_d;
  logic               ack_d, to_d, rw_d;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int unsigned        cand;

  assign dbg_state = state_q;

  always_comb begin
    // Round-robin search: the scan starts one past the last winner and wraps.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_q) + off) % NUM_REQ;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end

    state_d     = state_q;
    last_d      = last_q;
    wd_d        = wd_q;
    gnt_d       = gnt;
    rsp_valid_d = '0;
    rx_d        = rsp_rx_data;
    ack_d       = rsp_ack_error;
    to_d        = rsp_timeout;
    rw_d        = mbus.m_rw_bit;
    addr_d      = mbus.m_slave_addr;
    tx_d        = mbus.m_tx_data;

    case (state_q)
      IDLE: begin
        // Holding off while the engine reports busy keeps a start out of an
        // engine that is still stuck after a watchdog abort.
        if (win_found && !mbus.m_busy) begin
          rw_d           = req_rw[win_idx];
          addr_d         = req_addr[int'(win_idx)*7 +: 7];
          tx_d           = req_data[int'(win_idx)*8 +: 8];
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          last_d         = win_idx;
          wd_d           = '0;
          state_d        = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY, WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        // m_done takes priority over watchdog expiry in the same cycle.
        if (mbus.m_done) begin
          rx_d    = mbus.m_rx_data;
          ack_d   = mbus.m_ack_error;
          to_d    = 1'b0;
          state_d = RESPOND;
        end else if (wd_q == WD_MAX) begin
          rx_d    = 8'h00;
          ack_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESPOND;
        end else if (state_q == WAIT_BUSY && mbus.m_busy) begin
          state_d = WAIT_DONE;
        end
      end
      RESPOND: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RESPOND) rsp_valid_d = gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      last_q            <= LAST_RST;
      wd_q              <= '0;
      gnt               <= '0;
      rsp_valid         <= '0;
      rsp_rx_data       <= 8'h00;
      rsp_ack_error     <= 1'b0;
      rsp_timeout       <= 1'b0;
      arb_busy          <= 1'b0;
      mbus.m_start      <= 1'b0;
      mbus.m_rw_bit     <= 1'b0;
      mbus.m_slave_addr <= 7'h00;
      mbus.m_tx_data    <= 8'h00;
    end else begin
      state_q           <= state_d;
      last_q            <= last_d;
      wd_q              <= wd_d;
      gnt               <= gnt_d;
      rsp_valid         <= rsp_valid_d;
      rsp_rx_data       <= rx_d;
      rsp_ack_error     <= ack_d;
      rsp_timeout       <= to_d;
      arb_busy          <= (state_d != IDLE);
      mbus.m_start      <= (state_d == ISSUE);
      mbus.m_rw_bit     <= rw_d;
      mbus.m_slave_addr <= addr_d;
      mbus.m_tx_data    <= tx_d;
    end
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one `i2c_master` between `NUM_REQ` on-chip requesters, such as the button/switch front end, a register poller and a self-test engine. It latches one requester's transaction fields and issues a single-cycle start to the master. It then tracks the master's busy/done handshake and returns the read data and status to the owning requester as a one-cycle response. A watchdog aborts transactions that never complete.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `TIMEOUT_CYCLES`, default 2_000_000: watchdog limit in clk cycles (20 ms at 100 MHz); must be ≥ 16.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  NUM_REQ  per-requester request level.
- `req_rw`  in  NUM_REQ  per-requester R/W bit (1 = read).
- `req_addr`  in  7*NUM_REQ  per-requester 7-bit slave address; requester i uses bits [7i+6:7i].
- `req_data`  in  8*NUM_REQ  per-requester write byte; requester i uses bits [8i+7:8i].
- `gnt`  out  NUM_REQ  one-hot owner of the master; 0 when idle.
- `rsp_valid`  out  NUM_REQ  one-cycle pulse to the owner at completion.
- `rsp_rx_data`  out  8  read byte, shared by all requesters.
- `rsp_ack_error`  out  1  NACK or timeout.
- `rsp_timeout`  out  1  watchdog abort.
- `arb_busy`  out  1  state ≠ IDLE.
- `m_start`  out  1  start pulse to the master.
- `m_rw_bit`  out  1  R/W bit to the master.
- `m_slave_addr`  out  7  slave address to the master.
- `m_tx_data`  out  8  write byte to the master.
- `m_rx_data`  in  8  read byte from the master.
- `m_busy`  in  1  master busy.
- `m_done`  in  1  master done pulse.
- `m_ack_error`  in  1  master NACK flag.

## Operation
- All outputs are registered. Every output resets to 0.
- The round-robin pointer `last` resets to NUM_REQ-1, so requester 0 has first priority.
- State IDLE:
  - When `|req` is 1 and `m_busy` is 0, pick the first asserted requester searching from `last+1` with wrap-around.
  - Latch that requester's `req_rw`, `req_addr` and `req_data` into `m_rw_bit`, `m_slave_addr` and `m_tx_data`.
  - Set `gnt` one-hot, set `last` to the winner's index, clear the watchdog, and go to ISSUE.
- State ISSUE: `m_start` = 1 for exactly this cycle, then go to WAIT_BUSY.
- State WAIT_BUSY:
  - `m_done` = 1 goes to RESPOND. This covers a master that finishes without a visible busy phase.
  - Otherwise `m_busy` = 1 goes to WAIT_DONE.
- State WAIT_DONE: `m_done` = 1 goes to RESPOND.
- Capture on `m_done`: `rsp_rx_data` ← `m_rx_data`, `rsp_ack_error` ← `m_ack_error`, `rsp_timeout` ← 0.
- Watchdog:
  - Counts every cycle in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without `m_done`, go to RESPOND with `rsp_timeout` = 1, `rsp_ack_error` = 1, `rsp_rx_data` = 0.
  - If `m_done` and expiry occur in the same cycle, `m_done` wins and there is no timeout.
- State RESPOND:
  - `rsp_valid[owner]` = 1 for one cycle, then return to IDLE.
  - `gnt` clears on the IDLE entry edge.
- `m_slave_addr`, `m_rw_bit` and `m_tx_data` hold their latched values from ISSUE until the next grant; they are not cleared in IDLE.
- `rsp_*` data fields hold their values until the next capture.
- Requester changes to fields after the grant are ignored.
- A requester still holding `req` in IDLE after its response is a new request. Round-robin then favours the other requesters.
- `req` deasserted mid-transaction does not cancel the transaction; the response is still issued.
- After a timeout, IDLE does not grant while `m_busy` is 1. This prevents a start from being issued into a stuck master.
- Asynchronous reset mid-transaction returns to IDLE with all outputs at 0 and `last` = NUM_REQ-1. No response is issued.

## Timing
- Request latency: `req` sampled high in IDLE at edge k gives `gnt` and `m_*` fields valid after edge k, and `m_start` high in cycle k+1 only.
- Response latency: `m_done` sampled high at edge n puts `rsp_valid` high in cycle n+1. The state is IDLE after edge n+1.
- Minimum back-to-back spacing is 2 cycles between the RESPOND edge and the next `m_start`, given `m_busy` is low.
- Timeout occurs TIMEOUT_CYCLES cycles after the ISSUE→WAIT_BUSY edge.

## Test plan
- Single write: with NUM_REQ=2, requester 0 asserts req with addr 0x55, rw 0, data 0xA5. Expect `m_start` for 1 cycle, `m_slave_addr`=0x55, `m_tx_data`=0xA5, and `rsp_valid`=01 one cycle after `m_done`, with `rsp_ack_error`=0.
- Read with NACK: requester 1 issues a read; the master model returns `m_rx_data`=0x3C with `m_ack_error`=1. Expect `rsp_valid`=10, `rsp_rx_data`=0x3C, `rsp_ack_error`=1, `rsp_timeout`=0.
- Fairness: both requesters hold req continuously for 4 transactions. Grants must alternate 0,1,0,1, with exactly one `m_start` per grant.
- Timeout: TIMEOUT_CYCLES=16, and the master model raises `m_busy` but never `m_done`. Expect `rsp_timeout`=1, `rsp_ack_error`=1, `rsp_rx_data`=0 on the 16th WAIT cycle. No new grant until `m_busy` drops.
- Edge cases: `m_done` coincides with watchdog expiry, expecting a normal response with `rsp_timeout`=0. `m_done` arrives without `m_busy`, expecting a response. `rst_n` is pulsed low in WAIT_DONE, expecting all outputs 0, no `rsp_valid`, and the next grant going to requester 0.
